// File: rtl/negate_serial_if.sv
// negate_serial_if: operand/result handshake bundle for negate_serial.
// Revision 1.0
`default_nettype none

interface negate_serial_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );
endinterface

`default_nettype wire

// File: rtl/negate_serial.sv
// negate_serial: digit-serial two's-complement negate / absolute value, DIGIT bits per cycle.
// Revision 1.0 -- NEGATE_SERIAL_SAT_EN saturates the overflow case to the maximum positive value.
`default_nettype none

module negate_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   negate_serial_if.slave bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [CW-1:0]    LAST_DIG = CW'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             invert_q, invert_d;
   logic [WIDTH-1:0] operand_q, operand_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             in_ready;
   logic             accept;
   logic [DIGIT-1:0] digit_a;
   logic [DIGIT:0]   digit_sum;
   logic             ovf;

   assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign ovf      = invert_q && (operand_q == MOST_NEG);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      invert_d  = invert_q;
      operand_d = operand_q;
      result_d  = result_q;

      digit_a   = operand_q[cnt_q*DIGIT +: DIGIT];
      digit_sum = {1'b0, digit_a ^ {DIGIT{invert_q}}} + {{DIGIT{1'b0}}, carry_q};

      case (state_q)
         IDLE: ;
         BUSY: begin
            result_d[cnt_q*DIGIT +: DIGIT] = digit_sum[DIGIT-1:0];
            carry_d = digit_sum[DIGIT];
            if (cnt_q == LAST_DIG) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new operand (from IDLE, or back-to-back from DONE) overrides the above.
      if (accept) begin
         operand_d = bus.in_data;
         invert_d  = !bus.in_mode || bus.in_data[WIDTH-1];
         carry_d   = invert_d;
         cnt_d     = '0;
         result_d  = '0;
         state_d   = BUSY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         invert_q  <= 1'b0;
         operand_q <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         invert_q  <= invert_d;
         operand_q <= operand_d;
         result_q  <= result_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_ovf   = (state_q == DONE) && ovf;
`ifdef NEGATE_SERIAL_SAT_EN
   assign bus.out_data  = (state_q != DONE) ? '0 : (ovf ? MOST_POS : result_q);
`else
   assign bus.out_data  = (state_q != DONE) ? '0 : result_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_negate_serial.sv
// tb_negate_serial: random + directed checks of negate_serial against an arithmetic reference.
`default_nettype none

module tb_negate_serial;
   localparam int WIDTH = 8;
   localparam int DIGIT = 4;
   localparam int NDIG  = WIDTH / DIGIT;
   localparam int LAT   = NDIG + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   negate_serial_if #(.WIDTH(WIDTH)) bus ();

   negate_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: {ovf, result} from plain two's-complement arithmetic.
   function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] a, input logic m);
      logic             inv;
      logic             ov;
      logic [WIDTH-1:0] r;
      inv = !m || a[WIDTH-1];
      r   = inv ? WIDTH'(0 - int'(a)) : a;
      ov  = inv && (int'(a) == (1 << (WIDTH-1)));
`ifdef NEGATE_SERIAL_SAT_EN
      if (ov) r = WIDTH'((1 << (WIDTH-1)) - 1);
`endif
      return {ov, r};
   endfunction

   // Cycle-level model of the handshake: accept at cycle c -> result visible at c+LAT.
   int               cyc = 0;
   int               valid_at = 0;
   bit               pend = 0;
   bit               exp_ov = 0;
   bit               exp_rdy;
   logic [WIDTH:0]   pend_res;
   logic [WIDTH:0]   out_res;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         check("rst_out_valid", 32'(bus.out_valid), 32'd0);
         check("rst_out_data",  32'(bus.out_data),  32'd0);
         check("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
         pend   = 0;
         exp_ov = 0;
      end else begin
         if (pend && cyc == valid_at) begin
            exp_ov  = 1;
            out_res = pend_res;
            pend    = 0;
         end
         exp_rdy = !pend && (!exp_ov || bus.out_ready);
         check("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
         check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
         if (exp_ov) begin
            check("out_data", 32'(bus.out_data), 32'(out_res[WIDTH-1:0]));
            check("out_ovf",  32'(bus.out_ovf),  32'(out_res[WIDTH]));
         end
         if (exp_ov && bus.out_ready) exp_ov = 0;
         if (bus.in_valid && exp_rdy) begin
            pend     = 1;
            valid_at = cyc + LAT;
            pend_res = ref_op(bus.in_data, bus.in_mode);
         end
      end
   end

   task automatic wait_valid(input string nm, output int lat);
      bit got;
      got = 0;
      lat = 0;
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         got = bus.out_valid;
      end
      check({nm, "_timeout"}, 32'(got), 32'd1);
   endtask

   task automatic op(input logic [WIDTH-1:0] a, input logic m,
                     input logic [WIDTH-1:0] ed, input logic eo, input string nm);
      int lat;
      bit got;
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.in_data   = a;
      bus.in_mode   = m;
      bus.out_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = bus.in_ready;
      end
      check({nm, "_accept"}, 32'(got), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_valid(nm, lat);
      check({nm, "_latency"}, 32'(lat), 32'(LAT));
      check({nm, "_data"},    32'(bus.out_data), 32'(ed));
      check({nm, "_ovf"},     32'(bus.out_ovf),  32'(eo));
   endtask

   initial begin
      int lat;
      logic [WIDTH-1:0] d;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_mode   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed literal cases
      op(8'h05, 1'b0, 8'hFB, 1'b0, "neg05");
      op(8'hF0, 1'b1, 8'h10, 1'b0, "absF0");
      op(8'h22, 1'b1, 8'h22, 1'b0, "abs22");
      op(8'h00, 1'b0, 8'h00, 1'b0, "neg00");
      op(8'h7F, 1'b0, 8'h81, 1'b0, "neg7F");
      op(8'h01, 1'b1, 8'h01, 1'b0, "abs01");
`ifdef NEGATE_SERIAL_SAT_EN
      op(8'h80, 1'b0, 8'h7F, 1'b1, "neg80");
      op(8'h80, 1'b1, 8'h7F, 1'b1, "abs80");
`else
      op(8'h80, 1'b0, 8'h80, 1'b1, "neg80");
      op(8'h80, 1'b1, 8'h80, 1'b1, "abs80");
`endif

      // Backpressure in DONE, then back-to-back accept
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_data = 8'h05; bus.in_mode = 1'b0; bus.out_ready = 1'b0;
      @(negedge clk);
      check("bp_accept", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_valid("bp", lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_data",  32'(bus.out_data),  32'h0FB);
         check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
         check("bp_in_ready",   32'(bus.in_ready),  32'd0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h01; bus.in_mode = 1'b0;
      @(negedge clk);
      check("b2b_accept", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_valid("b2b", lat);
      check("b2b_latency", 32'(lat), 32'(LAT));
      check("b2b_data", 32'(bus.out_data), 32'h0FF);

      // Reset in the middle of BUSY
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_data = 8'h05; bus.in_mode = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_valid", 32'(bus.out_valid), 32'd0);
      check("abort_data",  32'(bus.out_data),  32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_no_result", 32'(bus.out_valid), 32'd0);
      end
      op(8'h03, 1'b0, 8'hFD, 1'b0, "after_rst");

      // Randomized traffic, model-checked every cycle
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         case ($urandom_range(0, 7))
            0:       d = 8'h80;
            1:       d = 8'h00;
            2:       d = 8'h7F;
            default: d = WIDTH'($urandom);
         endcase
         bus.in_valid  = ($urandom_range(0, 2) != 0);
         bus.in_data   = d;
         bus.in_mode   = 1'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (10) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
